// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding, Booth pair operation codes and small helper functions.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } booth_op_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((32'sd1 <<< bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    // Radix-2 Booth recoding of the pair {Q[0], q_m1}
    function automatic booth_op_t booth_decode(input logic q_lsb, input logic q_prev);
        booth_op_t op;
        case ({q_lsb, q_prev})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M into the
// WIDTH+1-bit accumulator, then arithmetic shift right of {A, Q, q_m1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    booth_op_t        op_s;
    logic [WIDTH:0]   sum_s;

    // Add/subtract selection followed by the shift of the combined register
    always_comb begin
        op_s = booth_decode(q[0], q_m1);
        case (op_s)
            OP_ADD:  sum_s = acc + m;
            OP_SUB:  sum_s = acc - m;
            default: sum_s = acc;
        endcase
        acc_next  = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_next    = {sum_s[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one recoding step per clock with a
// start/busy/done handshake; product holds the last completed result.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = clog2(WIDTH + 1);

    state_t               state_r;
    state_t               state_next_s;
    logic                 load_s;
    logic                 finish_s;

    logic [WIDTH:0]       acc_r;
    logic [WIDTH-1:0]     q_r;
    logic                 q_m1_r;
    logic [WIDTH:0]       m_r;
    logic [CW-1:0]        count_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 busy_r;
    logic                 done_r;

    logic [WIDTH:0]       acc_step_s;
    logic [WIDTH-1:0]     q_step_s;
    logic                 q_m1_step_s;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc       (acc_r),
        .q         (q_r),
        .q_m1      (q_m1_r),
        .m         (m_r),
        .acc_next  (acc_step_s),
        .q_next    (q_step_s),
        .q_m1_next (q_m1_step_s)
    );

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == CW'(WIDTH - 1)) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == CALC);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand load and per-cycle Booth iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= '0;
            q_r     <= '0;
            q_m1_r  <= 1'b0;
            m_r     <= '0;
            count_r <= '0;
        end else if (load_s) begin
            acc_r   <= '0;
            q_r     <= multiplier;
            q_m1_r  <= 1'b0;
            m_r     <= {multiplicand[WIDTH-1], multiplicand};
            count_r <= '0;
        end else if (state_r == CALC) begin
            acc_r   <= acc_step_s;
            q_r     <= q_step_s;
            q_m1_r  <= q_m1_step_s;
            count_r <= count_r + CW'(1);
        end
    end

    // Product is captured from the final shift so it appears together with done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_r <= '0;
        end else if (finish_s) begin
            product_r <= {acc_step_s[WIDTH-1:0], q_step_s};
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential radix-2 Booth multiplier for two's-complement operands of parametrised width.
- Performs one Booth recoding step per clock, with a start/busy/done handshake.
- Product register holds the result between operations.
- Arithmetic core of the Booth multiplication datapath; successor to the fixed combinational gate-level primitives.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- multiplicand  in  WIDTH  signed operand M; captured on accepted start
- multiplier  in  WIDTH  signed operand Q; captured on accepted start
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse when product updates
- product  out  2*WIDTH  signed M*Q of the last completed operation

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state=IDLE, busy=0, done=0, product=0.
  - All internal registers (A, Q, q_m1, M, count) = 0.
- Reset mid-CALC aborts the operation; product does not update.
- States:
  - IDLE: start=1 -> load, go to CALC.
  - CALC: runs exactly WIDTH cycles, then goes to DONE.
  - DONE: lasts 1 cycle; done=1. If start=1, load and go to CALC (back-to-back); else go to IDLE.
- Load:
  - A=0 (WIDTH+1 bits, sign-extended accumulator).
  - Q=multiplier; q_m1=0.
  - M=sign-extended multiplicand (WIDTH+1 bits); count=0.
- CALC step, on pair {Q[0], q_m1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00/11: A unchanged.
  - Then arithmetic shift right of {A,Q,q_m1} by 1; count++.
- The WIDTH+1-bit accumulator guarantees no overflow for M = -2^(WIDTH-1).
- Completion, on the final CALC cycle edge: product <= {A[WIDTH-1:0],Q} after the last shift.
  - This equals the exact 2*WIDTH-bit signed product.
  - done rises in the same cycle the state becomes DONE.
- Latency: start accepted at edge t -> busy high for cycles t+1..t+WIDTH -> done=1 and product valid in cycle t+WIDTH+1.
- start while busy=1 is ignored; operands are not re-sampled.
- Operand inputs may change freely after the accepting edge.
- product is stable except on the completion edge. It holds the old value throughout a new CALC.
- busy and done are never simultaneously high.
- count width: clog2(WIDTH+1); count compares against WIDTH-1 to exit CALC.

Decomposition:
- Shared package booth_pkg contains:
  - State encoding constants: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - Booth pair operation codes: NOP, ADD, SUB.
  - A clog2 helper function.
- One natural sub-module: booth_step. It is purely combinational, parametrised by WIDTH.
  - Inputs: A, Q, q_m1, M.
  - Outputs: next A, Q, q_m1 after add/sub and arithmetic shift.
  - The top holds the FSM, counter and registers.

Test Plan:
- WIDTH=8: M=3, Q=5, pulse start -> busy 8 cycles, done pulse in cycle 9, product=16'h000F.
- WIDTH=8 sign and extreme cases:
  - M=-7, Q=6 -> product=16'hFFD6 (-42).
  - M=-128, Q=-128 -> 16'h4000.
  - M=127, Q=-128 -> 16'hC080 (-16256).
- Start held/pulsed during CALC with different operands -> ignored; result matches the first operands; done pulses once.
- Back-to-back: start=1 during DONE with M=2, Q=-3 -> next CALC begins immediately; second done exactly 9 cycles later with product=16'hFFFA.
- rst_n low mid-CALC (cycle 4) -> busy=0, done=0, product=0 immediately; no done afterwards; a fresh start then computes correctly.
- WIDTH=4 build: exhaustive 256 operand pairs vs reference signed multiply; done always at start+5.
